// File: rtl/exec_debug_ctrl.sv
// exec_debug_ctrl: execution/debug sequencer for the BIP-I core.
// UART commands: 'r' run until HALT_OPCODE, 's' single step, 'c' clear.
// After a halt or a step, a 6-byte status report (PC, ACC, cycle count,
// each little-endian 16-bit) is streamed through the UART transmitter.
// Optional build macro DBG_ABORT_EN: while running, an 'h' byte aborts
// execution and triggers the report exactly as a halt would.
//
// Transmit handshake: o_tx_start is a one-cycle request carrying o_tx_data;
// o_tx_data stays stable until the transmitter answers with a one-cycle
// i_tx_done, and no new o_tx_start is issued before that answer arrives.
// o_dbg_state exposes the FSM state register for observation.
module exec_debug_ctrl #(
  parameter int                    PCLEN       = 11,
  parameter int                    DATA_LEN    = 16,
  parameter int                    OPCODE_LEN  = 5,
  parameter logic [OPCODE_LEN-1:0] HALT_OPCODE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic [OPCODE_LEN-1:0] i_opcode,
  input  logic [PCLEN-1:0]      i_pc,
  input  logic [DATA_LEN-1:0]   i_acc,
  output logic                  o_cpu_en,
  output logic                  o_cpu_rst,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    CLR  = 3'd3,
    SEND = 3'd4,
    WAIT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_inc;
  logic [15:0] snap_pc_q, snap_acc_q, snap_cnt_q;
  logic        take_snap;
  logic        cnt_clr;
  logic        not_halt;
  logic [7:0]  rpt_byte;

  assign not_halt = (i_opcode != HALT_OPCODE);

  // Next state, CPU enable and snapshot/clear strobes from the registered state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    o_cpu_en  = 1'b0;
    take_snap = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            8'h72:   state_d = RUN;
            8'h73:   state_d = STEP;
            8'h63:   state_d = CLR;
            default: state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        o_cpu_en = not_halt;
        if (!not_halt) begin
          take_snap = 1'b1;
          state_d   = SEND;
        end
`ifdef DBG_ABORT_EN
        if (i_rx_done && (i_rx_data == 8'h68)) begin
          o_cpu_en  = 1'b0;
          take_snap = 1'b1;
          state_d   = SEND;
        end
`endif
      end
      STEP: begin
        o_cpu_en  = not_halt;
        take_snap = 1'b1;
        state_d   = SEND;
      end
      CLR: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of enabled cycles, including the current one when enabled.
  always_comb begin
    cnt_inc = cnt_q;
    if (o_cpu_en && (cnt_q != 16'hFFFF)) cnt_inc = cnt_q + 16'd1;
  end

  // State, byte index, cycle counter and report snapshot registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 16'd0;
      snap_pc_q  <= 16'd0;
      snap_acc_q <= 16'd0;
      snap_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_clr ? 16'd0 : cnt_inc;
      if (take_snap) begin
        snap_pc_q  <= 16'(i_pc);
        snap_acc_q <= 16'(i_acc);
        snap_cnt_q <= cnt_inc;
      end
    end
  end

  // Report byte selected by the index; little-endian PC, ACC, count.
  always_comb begin
    rpt_byte = 8'h00;
    case (idx_q)
      3'd0:    rpt_byte = snap_pc_q[7:0];
      3'd1:    rpt_byte = snap_pc_q[15:8];
      3'd2:    rpt_byte = snap_acc_q[7:0];
      3'd3:    rpt_byte = snap_acc_q[15:8];
      3'd4:    rpt_byte = snap_cnt_q[7:0];
      3'd5:    rpt_byte = snap_cnt_q[15:8];
      default: rpt_byte = 8'h00;
    endcase
  end

  assign o_tx_start  = (state_q == SEND);
  assign o_tx_data   = ((state_q == SEND) || (state_q == WAIT)) ? rpt_byte : 8'h00;
  assign o_cpu_rst   = i_rst | (state_q == CLR);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_exec_debug_ctrl.sv
// Directed testbench for exec_debug_ctrl. Inputs are driven on the falling
// edge; the enable/start monitor samples just before each rising edge.
module tb_exec_debug_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic [4:0]  opcode;
  logic [10:0] pc;
  logic [15:0] acc;
  logic        cpu_en, cpu_rst, tx_start;
  logic [7:0]  tx_data;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int start_cnt = 0;
  logic timed_out = 1'b0;
  logic hold_bad = 1'b0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  exec_debug_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_opcode(opcode), .i_pc(pc), .i_acc(acc),
    .o_cpu_en(cpu_en), .o_cpu_rst(cpu_rst), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_dbg_state(dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  // Monitor: count enabled cycles and start pulses just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (cpu_en === 1'b1) en_cnt = en_cnt + 1;
    if (tx_start === 1'b1) start_cnt = start_cnt + 1;
  end

  // Driver: one-cycle rx pulse, entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Driver: answer n report bytes, holding i_tx_done off for hold extra cycles.
  task automatic drain(input int n, input int hold);
    logic [7:0] cap;
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (tx_start !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        timed_out = 1'b1;
        return;
      end
      cap = tx_data;
      obs_q.push_back(cap);
      for (int h = 0; h <= hold; h++) begin
        @(negedge clk);
        if (tx_start !== 1'b0 || tx_data !== cap) hold_bad = 1'b1;
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [15:0] p, input logic [15:0] a, input logic [15:0] c);
    exp_q.push_back(p[7:0]); exp_q.push_back(p[15:8]);
    exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]);
    exp_q.push_back(c[7:0]); exp_q.push_back(c[15:8]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    tests++; if (dbg_state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    tests++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx: got start=%b data=%h want 0/00", tx_start, tx_data); end
    rst = 1'b0;
    #1;
    tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL reset_release_cpu_rst: got %b want 0", cpu_rst); end
    @(negedge clk);
  endtask

  task automatic test_rst_vs_rx();
    rst = 1'b1;
    send_byte(8'h72);
    rst = 1'b0;
    tests++; if (dbg_state !== S_IDLE) begin fails++; $display("FAIL rst_wins_state: got %0d want %0d", dbg_state, S_IDLE); end
    @(negedge clk);
    tests++; if (cpu_en !== 1'b0 || dbg_state !== S_IDLE) begin fails++; $display("FAIL rst_wins_idle: got en=%b st=%0d want 0/0", cpu_en, dbg_state); end
  endtask

  task automatic test_step();
    int e0, s0;
    opcode = 5'd1; pc = 11'd3; acc = 16'h0042;
    e0 = en_cnt; s0 = start_cnt;
    send_byte(8'h73);
    tests++; if (cpu_en !== 1'b1 || dbg_state !== S_STEP) begin fails++; $display("FAIL step_en: got en=%b st=%0d want 1/%0d", cpu_en, dbg_state, S_STEP); end
    drain(6, 0);
    tests++; if (timed_out) begin fails++; $display("FAIL step_timeout: got timeout want report"); end
    push_exp(16'h0003, 16'h0042, 16'h0001);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL step_byte: got %h want %h", o, e); end
    end
    tests++; if (en_cnt - e0 != 1) begin fails++; $display("FAIL step_en_cycles: got %0d want 1", en_cnt - e0); end
    tests++; if (start_cnt - s0 != 6) begin fails++; $display("FAIL step_starts: got %0d want 6", start_cnt - s0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_halt_cmd();
    int e0;
    opcode = 5'd0; pc = 11'h123; acc = 16'h8001;
    e0 = en_cnt;
    send_byte(8'h72);
    tests++; if (cpu_en !== 1'b0 || dbg_state !== S_RUN) begin fails++; $display("FAIL halt_r_en: got en=%b st=%0d want 0/%0d", cpu_en, dbg_state, S_RUN); end
    drain(6, 0);
    send_byte(8'h73);
    drain(6, 0);
    tests++; if (timed_out) begin fails++; $display("FAIL halt_timeout: got timeout want report"); end
    push_exp(16'h0123, 16'h8001, 16'h0001);
    push_exp(16'h0123, 16'h8001, 16'h0001);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL halt_byte: got %h want %h", o, e); end
    end
    tests++; if (en_cnt != e0) begin fails++; $display("FAIL halt_en_cycles: got %0d want 0", en_cnt - e0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear();
    send_byte(8'h63);
    tests++; if (cpu_rst !== 1'b1 || dbg_state !== S_CLR) begin fails++; $display("FAIL clr_pulse: got rst=%b st=%0d want 1/%0d", cpu_rst, dbg_state, S_CLR); end
    @(negedge clk);
    tests++; if (cpu_rst !== 1'b0 || dbg_state !== S_IDLE) begin fails++; $display("FAIL clr_end: got rst=%b st=%0d want 0/0", cpu_rst, dbg_state); end
    opcode = 5'd7; pc = 11'h010; acc = 16'h1234;
    send_byte(8'h73);
    drain(6, 0);
    push_exp(16'h0010, 16'h1234, 16'h0001);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL clr_step_byte: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_run_hold();
    int e0, s0;
    send_byte(8'h63);
    @(negedge clk);
    opcode = 5'd9; pc = 11'h5A5; acc = 16'hBEEF;
    e0 = en_cnt; s0 = start_cnt;
    send_byte(8'h72);
    repeat (10) @(negedge clk);
    opcode = 5'd0;
    #1;
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL run_halt_en: got %b want 0", cpu_en); end
    hold_bad = 1'b0;
    drain(6, 50);
    tests++; if (timed_out) begin fails++; $display("FAIL run_timeout: got timeout want report"); end
    tests++; if (hold_bad) begin fails++; $display("FAIL run_hold: got data change or extra start want stable"); end
    push_exp(16'h05A5, 16'hBEEF, 16'h000A);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL run_byte: got %h want %h", o, e); end
    end
    tests++; if (en_cnt - e0 != 10) begin fails++; $display("FAIL run_en_cycles: got %0d want 10", en_cnt - e0); end
    tests++; if (start_cnt - s0 != 6) begin fails++; $display("FAIL run_starts: got %0d want 6", start_cnt - s0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_abort();
    int e0;
    logic [15:0] want_cnt;
    send_byte(8'h63);
    @(negedge clk);
    opcode = 5'd3; pc = 11'h7FF; acc = 16'h0000;
    e0 = en_cnt;
    send_byte(8'h72);
    repeat (5) @(negedge clk);
    send_byte(8'h68);
`ifdef DBG_ABORT_EN
    want_cnt = 16'd5;
`else
    want_cnt = 16'd10;
    repeat (4) @(negedge clk);
    opcode = 5'd0;
`endif
    drain(6, 0);
    tests++; if (timed_out) begin fails++; $display("FAIL abort_timeout: got timeout want report"); end
    push_exp(16'h07FF, 16'h0000, want_cnt);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL abort_byte: got %h want %h", o, e); end
    end
    tests++; if (en_cnt - e0 != int'(want_cnt)) begin fails++; $display("FAIL abort_en_cycles: got %0d want %0d", en_cnt - e0, want_cnt); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int s0, w;
    opcode = 5'd1; pc = 11'd1; acc = 16'd2;
    send_byte(8'h73);
    drain(2, 0);
    w = 0;
    while (tx_start !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    @(negedge clk);
    tests++; if (dbg_state !== S_WAIT) begin fails++; $display("FAIL mid_wait: got %0d want %0d", dbg_state, S_WAIT); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (dbg_state !== S_IDLE || tx_data !== 8'h00) begin fails++; $display("FAIL mid_abort: got st=%0d data=%h want 0/00", dbg_state, tx_data); end
    s0 = start_cnt;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (start_cnt != s0) begin fails++; $display("FAIL mid_no_resume: got %0d starts want 0", start_cnt - s0); end
    send_byte(8'h41);
    repeat (3) @(negedge clk);
    tests++; if (dbg_state !== S_IDLE || cpu_en !== 1'b0) begin fails++; $display("FAIL bogus_byte: got st=%0d en=%b want 0/0", dbg_state, cpu_en); end
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    opcode = 5'd1; pc = '0; acc = '0;
    @(negedge clk);
    test_reset();
    test_rst_vs_rx();
    test_step();
    test_halt_cmd();
    test_clear();
    test_run_hold();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
